// File: rtl/fw_ip3_cfg_chain_ctrl.sv
// IP3 configuration shift-chain sequencer: shifts a SW-written image out LSB first,
// captures the chain return into a readback image, then pulses the active-low load strobe.
module fw_ip3_cfg_chain_ctrl #(
   parameter int CFG_WORDS = 3,
   parameter int DIV_WIDTH = 8,
   parameter int LOAD_LEN  = 4
) (
   input  logic                                 fw_clk,
   input  logic                                 fw_rst,
   input  logic                                 cfg_wr_en,
   input  logic [$clog2(CFG_WORDS)-1:0]         cfg_wr_addr,
   input  logic [31:0]                          cfg_wr_data,
   input  logic [$clog2(CFG_WORDS)-1:0]         cfg_rd_addr,
   output logic [31:0]                          cfg_rd_data,
   input  logic [DIV_WIDTH-1:0]                 half_period,
   input  logic [$clog2(CFG_WORDS*32+1)-1:0]    nbits,
   input  logic                                 start,
   input  logic                                 status_clear,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err_start_busy,
   output logic                                 err_len,
   output logic                                 fw_config_clk,
   output logic                                 fw_config_in,
   output logic                                 fw_config_load,
   input  logic                                 fw_config_out
);

   localparam int TOTAL = CFG_WORDS * 32;
   localparam int AW    = $clog2(CFG_WORDS);
   localparam int NW    = $clog2(TOTAL + 1);
   localparam int LW    = $clog2(LOAD_LEN + 1);
   localparam int CW    = (DIV_WIDTH > LW) ? DIV_WIDTH : LW;

   localparam logic [NW-1:0] TOTAL_N   = NW'(TOTAL);
   localparam logic [NW-1:0] K_ONE     = NW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW-1:0] LAST_WORD = AW'(CFG_WORDS - 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_SHIFT_LO   = 3'd1;
   localparam logic [2:0] S_SHIFT_HI   = 3'd2;
   localparam logic [2:0] S_LOAD_SETUP = 3'd3;
   localparam logic [2:0] S_LOAD       = 3'd4;

   logic [2:0]           state;
   logic [DIV_WIDTH-1:0] h_q;
   logic [NW-1:0]        n_q;
   logic [NW-1:0]        k;
   logic [CW-1:0]        cnt;
   logic [31:0]          image    [CFG_WORDS];
   logic [31:0]          readback [CFG_WORDS];

   logic [DIV_WIDTH-1:0] h_eff;
   logic [CW-1:0]        h_reload;
   logic [NW-1:0]        k_next;
   logic                 nbits_ok;
   logic                 wr_addr_ok;
   logic                 rd_addr_ok;
   logic                 first_bit;
   logic                 cnt_zero;
   logic                 last_bit;

   // A same-cycle write to word 0 must reach the wire together with the start.
   always_comb begin
      h_eff      = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
      h_reload   = CW'(h_q) - CNT_ONE;
      k_next     = k + K_ONE;
      nbits_ok   = (nbits != '0) && (nbits <= TOTAL_N);
      wr_addr_ok = (cfg_wr_addr <= LAST_WORD);
      rd_addr_ok = (cfg_rd_addr <= LAST_WORD);
      first_bit  = (cfg_wr_en && (cfg_wr_addr == '0)) ? cfg_wr_data[0] : image[0][0];
      cnt_zero   = (cnt == '0);
      last_bit   = (k == (n_q - K_ONE));
   end

   always_ff @(posedge fw_clk) begin
      if (fw_rst) begin
         state          <= S_IDLE;
         h_q            <= '0;
         n_q            <= '0;
         k              <= '0;
         cnt            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_start_busy <= 1'b0;
         err_len        <= 1'b0;
         cfg_rd_data    <= '0;
         fw_config_clk  <= 1'b0;
         fw_config_in   <= 1'b0;
         fw_config_load <= 1'b1;
         for (int i = 0; i < CFG_WORDS; i++) begin
            image[i]    <= '0;
            readback[i] <= '0;
         end
      end else begin
         cfg_rd_data <= rd_addr_ok ? readback[cfg_rd_addr] : '0;

         // Clear first so that any set condition in the same cycle overrides it.
         if (status_clear) begin
            done           <= 1'b0;
            err_start_busy <= 1'b0;
            err_len        <= 1'b0;
         end
         if ((state != S_IDLE) && (start || cfg_wr_en))
            err_start_busy <= 1'b1;
         if ((state == S_IDLE) && cfg_wr_en && wr_addr_ok)
            image[cfg_wr_addr] <= cfg_wr_data;

         case (state)
            S_IDLE: begin
               if (start) begin
                  if (nbits_ok) begin
                     h_q          <= h_eff;
                     n_q          <= nbits;
                     k            <= '0;
                     cnt          <= CW'(h_eff) - CNT_ONE;
                     busy         <= 1'b1;
                     fw_config_in <= first_bit;
                     state        <= S_SHIFT_LO;
                  end else begin
                     err_len <= 1'b1;
                  end
               end
            end
            S_SHIFT_LO: begin
               if (cnt_zero) begin
                  fw_config_clk <= 1'b1;
                  cnt           <= h_reload;
                  state         <= S_SHIFT_HI;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_SHIFT_HI: begin
               if (cnt_zero) begin
                  readback[k[NW-1:5]][k[4:0]] <= fw_config_out;
                  fw_config_clk <= 1'b0;
                  cnt           <= h_reload;
                  if (last_bit) begin
                     state <= S_LOAD_SETUP;
                  end else begin
                     k            <= k_next;
                     fw_config_in <= image[k_next[NW-1:5]][k_next[4:0]];
                     state        <= S_SHIFT_LO;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_LOAD_SETUP: begin
               if (cnt_zero) begin
                  fw_config_load <= 1'b0;
                  cnt            <= CW'(LOAD_LEN - 1);
                  state          <= S_LOAD;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            S_LOAD: begin
               if (cnt_zero) begin
                  fw_config_load <= 1'b1;
                  fw_config_in   <= 1'b0;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  state          <= S_IDLE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fw_ip3_cfg_chain_ctrl.sv
// Self-checking bench for fw_ip3_cfg_chain_ctrl: directed register-level vectors plus
// hand-written shift sequences with an external loopback chain model.
module tb_fw_ip3_cfg_chain_ctrl;

   localparam int CFG_WORDS = 3;
   localparam int DIV_WIDTH = 8;
   localparam int LOAD_LEN  = 4;

   localparam logic [31:0] IMG0     = 32'hA5A5_0001;
   localparam logic [31:0] IMG1     = 32'h0000_FFFF;
   localparam logic [31:0] IMG2     = 32'h8000_0000;
   localparam logic [95:0] IMG_FLAT = {IMG2, IMG1, IMG0};
   localparam logic [95:0] ZERO_IMG = '0;
   // Loopback delays one config_clk period; its first output is the initial value 1.
   localparam logic [31:0] RB0      = {IMG0[30:0], 1'b1};
   localparam logic [31:0] RB1      = {IMG1[30:0], IMG0[31]};
   localparam logic [31:0] RB2      = {IMG2[30:0], IMG1[31]};

   logic        fw_clk = 1'b0;
   logic        fw_rst;
   logic        cfg_wr_en;
   logic [1:0]  cfg_wr_addr;
   logic [31:0] cfg_wr_data;
   logic [1:0]  cfg_rd_addr;
   logic [31:0] cfg_rd_data;
   logic [7:0]  half_period;
   logic [6:0]  nbits;
   logic        start;
   logic        status_clear;
   logic        busy;
   logic        done;
   logic        err_start_busy;
   logic        err_len;
   logic        fw_config_clk;
   logic        fw_config_in;
   logic        fw_config_load;
   logic        fw_config_out;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   typedef struct {
      string       name;
      logic        wr_en;
      logic [1:0]  wr_addr;
      logic [31:0] wr_data;
      logic [1:0]  rd_addr;
      logic        start;
      logic [6:0]  nbits;
      logic        clr;
      logic [31:0] exp_rd;
      logic        exp_busy;
      logic        exp_done;
      logic        exp_err_len;
      logic        exp_err_sb;
      logic        exp_cfg_clk;
   } vec_t;

   vec_t vecs[10];

   fw_ip3_cfg_chain_ctrl #(
      .CFG_WORDS(CFG_WORDS),
      .DIV_WIDTH(DIV_WIDTH),
      .LOAD_LEN (LOAD_LEN)
   ) dut (
      .fw_clk        (fw_clk),
      .fw_rst        (fw_rst),
      .cfg_wr_en     (cfg_wr_en),
      .cfg_wr_addr   (cfg_wr_addr),
      .cfg_wr_data   (cfg_wr_data),
      .cfg_rd_addr   (cfg_rd_addr),
      .cfg_rd_data   (cfg_rd_data),
      .half_period   (half_period),
      .nbits         (nbits),
      .start         (start),
      .status_clear  (status_clear),
      .busy          (busy),
      .done          (done),
      .err_start_busy(err_start_busy),
      .err_len       (err_len),
      .fw_config_clk (fw_config_clk),
      .fw_config_in  (fw_config_in),
      .fw_config_load(fw_config_load),
      .fw_config_out (fw_config_out)
   );

   always #5 fw_clk = ~fw_clk;

   always @(posedge fw_clk) edge_cnt <= edge_cnt + 1;

   // External chain model: two flops clocked by the config clock.
   logic lb_en  = 1'b0;
   logic lb_q   = 1'b1;
   logic lb_out = 1'b0;
   always @(posedge fw_config_clk) begin
      lb_out <= lb_q;
      lb_q   <= fw_config_in;
   end
   assign fw_config_out = lb_en ? lb_out : 1'b0;

   // Edge/level monitor sampled on the inactive clock edge.
   int   rise_edge[$];
   logic rise_bit[$];
   int   load_fall_edge = -1;
   int   load_low_cycles = 0;
   int   busy_fall_edge = -1;
   logic prev_clk  = 1'b0;
   logic prev_load = 1'b1;
   logic prev_busy = 1'b0;

   always @(negedge fw_clk) begin
      if (!prev_clk && fw_config_clk) begin
         rise_edge.push_back(edge_cnt);
         rise_bit.push_back(fw_config_in);
      end
      if (prev_load && !fw_config_load) load_fall_edge = edge_cnt;
      if (fw_config_load === 1'b0) load_low_cycles++;
      if (prev_busy && !busy) busy_fall_edge = edge_cnt;
      prev_clk  = fw_config_clk;
      prev_load = fw_config_load;
      prev_busy = busy;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      cfg_wr_en    = v.wr_en;
      cfg_wr_addr  = v.wr_addr;
      cfg_wr_data  = v.wr_data;
      cfg_rd_addr  = v.rd_addr;
      start        = v.start;
      nbits        = v.nbits;
      status_clear = v.clr;
   endtask

   task automatic idle_inputs();
      start        = 1'b0;
      cfg_wr_en    = 1'b0;
      status_clear = 1'b0;
   endtask

   task automatic clear_mon();
      rise_edge.delete();
      rise_bit.delete();
      load_fall_edge  = -1;
      load_low_cycles = 0;
      busy_fall_edge  = -1;
   endtask

   // Called at a negedge; returns the edge index T at which start is accepted.
   task automatic start_seq(input logic [7:0] h, input logic [6:0] n, output int t);
      half_period = h;
      nbits       = n;
      start       = 1'b1;
      t           = edge_cnt + 1;
      @(negedge fw_clk);
      start       = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i = 0;
      while (busy && i < budget) begin
         @(negedge fw_clk);
         i++;
      end
      if (busy) checkOutput({name, " busy timeout"}, {31'b0, busy}, 32'd0);
      @(negedge fw_clk);
   endtask

   task automatic check_run(input string tag, input int t, input int h, input int n, input logic [95:0] exp_img);
      int bad_edge = 0;
      int bad_bit  = 0;
      checkOutput({tag, " rise count"}, rise_edge.size(), n);
      for (int k = 0; k < rise_edge.size() && k < n; k++) begin
         if (rise_edge[k] - t != h + 2 * k * h) bad_edge++;
         if (rise_bit[k] !== exp_img[k]) bad_bit++;
      end
      checkOutput({tag, " rise timing errors"}, bad_edge, 0);
      checkOutput({tag, " serial bit errors"}, bad_bit, 0);
      checkOutput({tag, " load fall offset"}, load_fall_edge - t, 2 * h * n + h);
      checkOutput({tag, " load low cycles"}, load_low_cycles, LOAD_LEN);
      checkOutput({tag, " busy fall offset"}, busy_fall_edge - t, 2 * h * n + h + LOAD_LEN);
      checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
      checkOutput({tag, " load idle"}, {31'b0, fw_config_load}, 32'd1);
      checkOutput({tag, " in idle"}, {31'b0, fw_config_in}, 32'd0);
   endtask

   task automatic check_flags(input string tag, input logic b, input logic d, input logic el, input logic es);
      checkOutput({tag, " busy"}, {31'b0, busy}, {31'b0, b});
      checkOutput({tag, " done"}, {31'b0, done}, {31'b0, d});
      checkOutput({tag, " err_len"}, {31'b0, err_len}, {31'b0, el});
      checkOutput({tag, " err_start_busy"}, {31'b0, err_start_busy}, {31'b0, es});
   endtask

   initial begin
      int t;

      vecs[0] = '{"rd w0",   1'b0, 2'd0, 32'h0,         2'd0, 1'b0, 7'd0,  1'b0, RB0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"rd w1",   1'b0, 2'd0, 32'h0,         2'd1, 1'b0, 7'd0,  1'b0, RB1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{"rd w2",   1'b0, 2'd0, 32'h0,         2'd2, 1'b0, 7'd0,  1'b0, RB2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{"rd oob",  1'b0, 2'd0, 32'h0,         2'd3, 1'b0, 7'd0,  1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{"n=0",     1'b0, 2'd0, 32'h0,         2'd0, 1'b1, 7'd0,  1'b0, RB0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{"clr",     1'b0, 2'd0, 32'h0,         2'd1, 1'b0, 7'd0,  1'b1, RB1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{"n=97",    1'b0, 2'd0, 32'h0,         2'd0, 1'b1, 7'd97, 1'b0, RB0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{"n=97+clr",1'b0, 2'd0, 32'h0,         2'd2, 1'b1, 7'd97, 1'b1, RB2,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{"clr2",    1'b0, 2'd0, 32'h0,         2'd1, 1'b0, 7'd0,  1'b1, RB1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{"wr oob",  1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 1'b0, 7'd0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      fw_rst       = 1'b1;
      cfg_wr_en    = 1'b0;
      cfg_wr_addr  = '0;
      cfg_wr_data  = '0;
      cfg_rd_addr  = '0;
      half_period  = '0;
      nbits        = '0;
      start        = 1'b0;
      status_clear = 1'b0;
      repeat (3) @(negedge fw_clk);
      fw_rst = 1'b0;
      @(negedge fw_clk);

      check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset rd_data", cfg_rd_data, 32'h0);
      checkOutput("reset cfg_clk", {31'b0, fw_config_clk}, 32'd0);
      checkOutput("reset cfg_in", {31'b0, fw_config_in}, 32'd0);
      checkOutput("reset cfg_load", {31'b0, fw_config_load}, 32'd1);

      // Full-length shift with loopback; word 0 is written in the start cycle itself.
      cfg_wr_en = 1'b1; cfg_wr_addr = 2'd1; cfg_wr_data = IMG1;
      @(negedge fw_clk);
      cfg_wr_addr = 2'd2; cfg_wr_data = IMG2;
      @(negedge fw_clk);
      cfg_wr_addr = 2'd0; cfg_wr_data = IMG0;
      lb_en = 1'b1;
      clear_mon();
      start_seq(8'd2, 7'd96, t);
      cfg_wr_en = 1'b0;
      wait_idle("full", 1000);
      check_run("full", t, 2, 96, IMG_FLAT);
      lb_en = 1'b0;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         @(negedge fw_clk);
         idle_inputs();
         checkOutput({vecs[i].name, " rd_data"}, cfg_rd_data, vecs[i].exp_rd);
         check_flags(vecs[i].name, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_err_len, vecs[i].exp_err_sb);
         checkOutput({vecs[i].name, " cfg_clk"}, {31'b0, fw_config_clk}, {31'b0, vecs[i].exp_cfg_clk});
      end

      // half_period of zero behaves as one, single-bit chain.
      clear_mon();
      start_seq(8'd0, 7'd1, t);
      wait_idle("h0", 100);
      check_run("h0", t, 1, 1, IMG_FLAT);

      // Start and write while busy: flagged, ignored, and clear loses to a new error.
      clear_mon();
      start_seq(8'd1, 7'd8, t);
      repeat (3) @(negedge fw_clk);
      start = 1'b1; cfg_wr_en = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = 32'hDEAD_BEEF;
      @(negedge fw_clk);
      idle_inputs();
      checkOutput("busy err set", {31'b0, err_start_busy}, 32'd1);
      start = 1'b1; status_clear = 1'b1;
      @(negedge fw_clk);
      idle_inputs();
      checkOutput("busy err set beats clr", {31'b0, err_start_busy}, 32'd1);
      status_clear = 1'b1;
      @(negedge fw_clk);
      idle_inputs();
      checkOutput("busy err cleared", {31'b0, err_start_busy}, 32'd0);
      wait_idle("busyerr", 200);
      check_run("busyerr", t, 1, 8, IMG_FLAT);

      clear_mon();
      start_seq(8'd1, 7'd32, t);
      wait_idle("image kept", 200);
      check_run("image kept", t, 1, 32, IMG_FLAT);

      // Reset in the high phase of bit 40.
      clear_mon();
      start_seq(8'd2, 7'd96, t);
      while (edge_cnt < t + 162) @(negedge fw_clk);
      checkOutput("pre-rst cfg_clk", {31'b0, fw_config_clk}, 32'd1);
      checkOutput("pre-rst cfg_in bit40", {31'b0, fw_config_in}, {31'b0, IMG_FLAT[40]});
      checkOutput("pre-rst busy", {31'b0, busy}, 32'd1);
      fw_rst = 1'b1;
      @(negedge fw_clk);
      fw_rst = 1'b0;
      checkOutput("rst cfg_clk", {31'b0, fw_config_clk}, 32'd0);
      checkOutput("rst cfg_in", {31'b0, fw_config_in}, 32'd0);
      checkOutput("rst cfg_load", {31'b0, fw_config_load}, 32'd1);
      check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 3; w++) begin
         cfg_rd_addr = 2'(w);
         @(negedge fw_clk);
         checkOutput($sformatf("rst readback w%0d", w), cfg_rd_data, 32'h0);
      end
      clear_mon();
      start_seq(8'd1, 7'd32, t);
      wait_idle("post-rst", 200);
      check_run("post-rst", t, 1, 32, ZERO_IMG);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fw_ip3_cfg_chain_ctrl.md
Name: fw_ip3_cfg_chain_ctrl

Overview:
Sequencer for the DUT configuration shift chain driven by the IP3 firmware slot. It holds a SW-written config image, shifts it serially onto fw_config_in with a programmable-rate fw_config_clk, and captures fw_config_out into a readback image. It then pulses fw_config_load (active-low) to commit, and reports busy/done/error status for fw_read_status32.

Parameters:
CFG_WORDS, 3, number of 32-bit image words (TOTAL = CFG_WORDS*32 bits)
DIV_WIDTH, 8, width of half-period divider
LOAD_LEN, 4, fw_config_load low-pulse length in fw_clk cycles (>=1)

Ports:
fw_clk  in  1  clock
fw_rst  in  1  synchronous reset, active-high
cfg_wr_en  in  1  write image word
cfg_wr_addr  in  clog2(CFG_WORDS)  image word index
cfg_wr_data  in  32  image word
cfg_rd_addr  in  clog2(CFG_WORDS)  readback word index
cfg_rd_data  out  32  captured readback word, registered
half_period  in  DIV_WIDTH  fw_clk cycles per config_clk phase (0 treated as 1)
nbits  in  clog2(TOTAL+1)  chain length to shift
start  in  1  one-cycle start pulse (op_code_w_execute)
status_clear  in  1  clears done/error flags
busy  out  1  sequence in progress
done  out  1  sticky, sequence completed
err_start_busy  out  1  sticky, start or write while busy
err_len  out  1  sticky, start with nbits==0 or nbits>TOTAL
fw_config_clk  out  1  chain clock to DUT
fw_config_in  out  1  chain serial data to DUT
fw_config_load  out  1  chain load, active-low
fw_config_out  in  1  chain serial data from DUT

Behaviour:
- Reset: busy=0, done=0, errors=0, cfg_rd_data=0, fw_config_clk=0, fw_config_in=0, fw_config_load=1. The image and readback arrays are cleared to 0. Reset mid-sequence aborts, and outputs take reset values on the next edge.
- All outputs are registered.
- States: IDLE, SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD.
- IDLE, start=1, nbits valid:
  - latch H=max(half_period,1) and N=nbits; bit index k=0
  - go SHIFT_LO; busy=1 next cycle
  - fw_config_in=image bit 0 in that same cycle
- IDLE, start with invalid nbits: set err_len; stay IDLE; outputs unchanged.
- Bit order: LSB first, bit k = word k/32, bit k%32.
- SHIFT_LO: fw_config_clk=0 for H cycles; fw_config_in holds bit k; then SHIFT_HI.
- SHIFT_HI: fw_config_clk=1 for H cycles.
  - In the last cycle, sample fw_config_out into readback bit k.
  - If k==N-1: go LOAD_SETUP with fw_config_clk=0. Else k++, fw_config_in=bit k, go SHIFT_LO.
- LOAD_SETUP: H cycles, clk low, fw_config_in held; then LOAD.
- LOAD: fw_config_load=0 for LOAD_LEN cycles. Then fw_config_load=1, busy=0, done=1 on the same edge; return to IDLE; fw_config_in returns to 0.
- Timing, start accepted at edge T:
  - fw_config_clk rising edges at T+H+2kH
  - load low from T+2HN+H, for LOAD_LEN cycles
  - busy falls at T+2HN+H+LOAD_LEN
- While busy:
  - start and cfg_wr_en are ignored and set err_start_busy
  - half_period/nbits changes have no effect (latched)
- status_clear: clears done and both errors next cycle. If a set condition occurs in the same cycle, the set wins.
- cfg_rd_data: readback[cfg_rd_addr], 1-cycle latency; out-of-range address returns 0. Reads are legal while busy; they return partially captured data.
- Image writes in IDLE take effect next cycle. Write and start in the same IDLE cycle: the write lands first, and the shift uses the new word.
- Out-of-range cfg_wr_addr writes are dropped silently.
- H counter and k counter have no wrap. Maximum duration 2*H*TOTAL+H+LOAD_LEN, with H up to 2^DIV_WIDTH-1.

Test Plan:
- Reset, write words {32'hA5A5_0001, 32'h0000_FFFF, 32'h8000_0000}, H=2, N=96, start. Then:
  - fw_config_in sequence matches LSB-first image
  - 96 rising clk edges, 4 cycles apart
  - load low for 4 cycles starting at T+386
  - busy falls at T+390, done=1
- Loopback fw_config_out=fw_config_in delayed by one config_clk period. Then readback word 0 = image word 0 shifted by one bit, with the first bit equal to the DUT initial value.
- H=0, N=1: behaves as H=1; busy spans exactly 1+1+1+LOAD_LEN... i.e. falls at T+7.
- Start with N=0, then N=97: err_len=1, no clk toggles, busy stays 0. status_clear -> err_len=0.
- Start and cfg_wr_en mid-shift: err_start_busy=1, image unchanged, sequence completes normally. status_clear coincident with a new error leaves the flag at 1.
- fw_rst asserted during SHIFT_HI at k=40. Next cycle: clk=0, in=0, load=1, busy=0, done=0, arrays zero. A new start then runs cleanly.
